// File: rtl/jedro_1_mem_arbiter_if.sv
// Bus bundle between the two requesters (fetch, LSU), the arbiter and the
// single-port RAM. The arbiter uses the slave view; the requesters and RAM
// (the environment around the arbiter) use the master view.
interface jedro_1_mem_arbiter_if #(
   parameter int AW = 12
);
   logic          instr_req_i;
   logic [31:0]   instr_addr_i;
   logic          instr_gnt_o;
   logic          instr_rvalid_o;
   logic [31:0]   instr_rdata_o;
   logic          instr_err_o;

   logic          data_req_i;
   logic          data_we_i;
   logic [3:0]    data_be_i;
   logic [31:0]   data_addr_i;
   logic [31:0]   data_wdata_i;
   logic          data_gnt_o;
   logic          data_rvalid_o;
   logic [31:0]   data_rdata_o;
   logic          data_err_o;

   logic          mem_en_o;
   logic [3:0]    mem_we_o;
   logic [AW-1:0] mem_addr_o;
   logic [31:0]   mem_wdata_o;
   logic [31:0]   mem_rdata_i;

   modport slave (
      input  instr_req_i, instr_addr_i,
      output instr_gnt_o, instr_rvalid_o, instr_rdata_o, instr_err_o,
      input  data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
      output data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o,
      output mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
      input  mem_rdata_i
   );

   modport master (
      output instr_req_i, instr_addr_i,
      input  instr_gnt_o, instr_rvalid_o, instr_rdata_o, instr_err_o,
      output data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
      input  data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o,
      input  mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
      output mem_rdata_i
   );
endinterface

// File: rtl/jedro_1_mem_arbiter.sv
// Two-requester arbiter in front of a single-port synchronous RAM.
// Data has priority; a streak counter forces one fetch grant after
// MAX_DATA_STREAK contested data grants. Grants are combinational and each
// grant produces exactly one response on the following cycle.
module jedro_1_mem_arbiter #(
   parameter logic [31:0] MEM_BASE        = 32'h8000_0000,
   parameter int unsigned MEM_SIZE_WORDS  = 4096,
   parameter int unsigned MAX_DATA_STREAK = 4
) (
   input logic clk_i,
   input logic rstn_i,
   jedro_1_mem_arbiter_if.slave bus
);
   localparam int AW = $clog2(MEM_SIZE_WORDS);
   localparam int SW = $clog2(MAX_DATA_STREAK + 1);
   localparam logic [31:0]   MEM_BYTES  = 32'(MEM_SIZE_WORDS) << 2;
   localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DATA_STREAK);

   typedef enum logic [1:0] {
      OWN_NONE  = 2'd0,
      OWN_INSTR = 2'd1,
      OWN_DATA  = 2'd2
   } owner_e;

   owner_e        owner_r, owner_s;
   logic          err_r, err_s;
   logic          rd_r, rd_s;
   logic [SW-1:0] streak_r, streak_s;

   logic          contested_s, force_fetch_s;
   logic          gnt_data_s, gnt_instr_s, gnt_any_s;
   logic          in_range_s, is_write_s;
   logic [31:0]   sel_addr_s, offset_s;

   // Arbitration and window decode of the granted request (grants held off in reset)
   always_comb begin
      contested_s   = bus.instr_req_i & bus.data_req_i;
      force_fetch_s = contested_s & (streak_r == STREAK_MAX);
      gnt_data_s    = rstn_i & bus.data_req_i & ~force_fetch_s;
      gnt_instr_s   = rstn_i & bus.instr_req_i & ~gnt_data_s;
      gnt_any_s     = gnt_data_s | gnt_instr_s;
      if (gnt_data_s) begin
         sel_addr_s = bus.data_addr_i;
      end else begin
         sel_addr_s = bus.instr_addr_i;
      end
      // Unsigned wrap makes addresses below the base look huge, so one compare suffices
      offset_s   = sel_addr_s - MEM_BASE;
      in_range_s = (offset_s < MEM_BYTES);
      is_write_s = gnt_data_s & bus.data_we_i;
   end

   // RAM port drive and grant outputs; out-of-window accesses never touch the RAM
   always_comb begin
      bus.instr_gnt_o = gnt_instr_s;
      bus.data_gnt_o  = gnt_data_s;
      bus.mem_en_o    = gnt_any_s & in_range_s;
      if (is_write_s && in_range_s) begin
         bus.mem_we_o = bus.data_be_i;
      end else begin
         bus.mem_we_o = 4'b0000;
      end
      bus.mem_addr_o  = offset_s[AW+1:2];
      bus.mem_wdata_o = bus.data_wdata_i;
   end

   // Next response owner and streak counter
   always_comb begin
      owner_s  = OWN_NONE;
      err_s    = 1'b0;
      rd_s     = 1'b0;
      streak_s = streak_r;
      if (gnt_data_s) begin
         owner_s = OWN_DATA;
      end else if (gnt_instr_s) begin
         owner_s = OWN_INSTR;
      end else begin
         owner_s = OWN_NONE;
      end
      err_s = gnt_any_s & ~in_range_s;
      rd_s  = gnt_any_s & in_range_s & ~is_write_s;
      if (!bus.instr_req_i || gnt_instr_s) begin
         streak_s = '0;
      end else if (contested_s && gnt_data_s && (streak_r != STREAK_MAX)) begin
         streak_s = streak_r + SW'(1);
      end else begin
         streak_s = streak_r;
      end
   end

   // State registers; reset drops any in-flight response
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         owner_r  <= OWN_NONE;
         err_r    <= 1'b0;
         rd_r     <= 1'b0;
         streak_r <= '0;
      end else begin
         owner_r  <= owner_s;
         err_r    <= err_s;
         rd_r     <= rd_s;
         streak_r <= streak_s;
      end
   end

   // Route the response to its owner; writes and errors return zero data
   always_comb begin
      bus.instr_rvalid_o = (owner_r == OWN_INSTR);
      bus.data_rvalid_o  = (owner_r == OWN_DATA);
      bus.instr_err_o    = (owner_r == OWN_INSTR) & err_r;
      bus.data_err_o     = (owner_r == OWN_DATA) & err_r;
      if ((owner_r == OWN_INSTR) && rd_r) begin
         bus.instr_rdata_o = bus.mem_rdata_i;
      end else begin
         bus.instr_rdata_o = 32'h0000_0000;
      end
      if ((owner_r == OWN_DATA) && rd_r) begin
         bus.data_rdata_o = bus.mem_rdata_i;
      end else begin
         bus.data_rdata_o = 32'h0000_0000;
      end
   end
endmodule

// File: doc/jedro_1_mem_arbiter.md
Name: jedro_1_mem_arbiter

Overview:
Shares a single-port synchronous RAM between two requesters: the instruction fetch unit and the load/store unit.
- RAM has one-cycle read latency.
- Both requester ports use the same req/gnt/rvalid protocol as the core's instruction memory interface.
- Grants are combinational. Each granted access returns exactly one rvalid on the following cycle.
- Data accesses have fixed priority. A streak counter stops fetch from being starved.
- Accesses outside the RAM window complete with an error and do not touch the RAM.

Parameters:
- MEM_BASE, 32'h8000_0000, byte base address of the RAM window (word aligned).
- MEM_SIZE_WORDS, 4096, RAM depth in 32-bit words (power of two, >=2).
- MAX_DATA_STREAK, 4, consecutive contested data grants allowed before one fetch grant is forced (>=1).
- Local: AW = $clog2(MEM_SIZE_WORDS).

Ports:
- clk_i  in  1  clock
- rstn_i  in  1  asynchronous active-low reset
- instr_req_i  in  1  fetch request
- instr_addr_i  in  32  fetch byte address
- instr_gnt_o  out  1  fetch request accepted this cycle
- instr_rvalid_o  out  1  fetch response valid
- instr_rdata_o  out  32  fetch read data
- instr_err_o  out  1  fetch response error (valid with rvalid)
- data_req_i  in  1  LSU request
- data_we_i  in  1  1 = write
- data_be_i  in  4  byte enables
- data_addr_i  in  32  LSU byte address
- data_wdata_i  in  32  write data
- data_gnt_o  out  1  LSU request accepted
- data_rvalid_o  out  1  LSU response valid (also asserted for writes)
- data_rdata_o  out  32  LSU read data
- data_err_o  out  1  LSU response error
- mem_en_o  out  1  RAM enable
- mem_we_o  out  4  RAM byte write enables
- mem_addr_o  out  AW  RAM word address
- mem_wdata_o  out  32  RAM write data
- mem_rdata_i  in  32  RAM read data, one cycle after mem_en_o

Behaviour:
- Reset (async assert, sync release):
  - all gnt/rvalid/err outputs 0; mem_en_o = 0; mem_we_o = 0;
  - streak counter = 0; response owner = NONE;
  - any in-flight response is discarded, so no rvalid appears after reset release for a pre-reset grant.
- Address decode:
  - in_range = (addr - MEM_BASE) < MEM_SIZE_WORDS*4, computed as a 32-bit unsigned compare.
  - mem_addr_o = (addr - MEM_BASE)[AW+1:2].
  - addr[1:0] is ignored.
- Arbitration (combinational, same cycle):
  - Only data_req_i high: data granted.
  - Only instr_req_i high: fetch granted.
  - Both high (contested): data granted unless streak == MAX_DATA_STREAK, in which case fetch is granted.
  - At most one gnt per cycle. The ungranted requester must hold req and its payload stable.
- Streak counter (0..MAX_DATA_STREAK, saturating):
  - increments on a contested data grant;
  - clears to 0 on any fetch grant or any cycle with instr_req_i = 0;
  - otherwise holds.
- RAM drive: mem_en_o = gnt_any & in_range of the granted request.
  - Granted write: mem_we_o = data_be_i.
  - Otherwise: mem_we_o = 0.
  - mem_wdata_o = data_wdata_i.
- Response stage:
  - Registered owner ∈ {NONE, INSTR, DATA} plus a registered err bit, loaded on each grant.
  - owner becomes NONE when there is no grant.
  - On the cycle after a grant, the owner's rvalid = 1 and err = registered err.
  - Read rdata = mem_rdata_i.
  - Write or error: rdata = 32'h0.
  - The non-owner rdata is 32'h0.
- Throughput: back-to-back grants every cycle, with zero bubbles between requesters. No more than one outstanding response per port.
- Out-of-range access: granted normally; mem_en_o = 0; err = 1 next cycle; counts toward the streak exactly like a valid access.
- data_be_i = 0 on a write: treated as a normal granted write (en = 1, we = 0), with an ordinary rvalid.

Test Plan:
- Reset, then instr_req=1 at addr 8000_0010 with RAM[4]=0x00000013 → same-cycle instr_gnt=1, mem_addr=4; next cycle instr_rvalid=1, rdata=0x00000013, err=0.
- Write data_be=4'b0011, wdata=0xAABBCCDD to 8000_0020, then read it back → mem_we=0011 on the write; the read returns the RAM's original upper bytes with 0xCCDD in the low half; both responses have data_rvalid=1.
- Both reqs held high for 10 cycles with MAX_DATA_STREAK=4 → grant pattern D,D,D,D,I,D,D,D,D,I; each rvalid lands on the correct port one cycle after its grant.
- data read at 0x0000_1000 (out of range) → data_gnt=1, mem_en=0; next cycle data_rvalid=1, data_err=1, rdata=0.
- Assert rstn_i low asynchronously the cycle after a fetch grant → instr_rvalid and mem_en drop immediately; no rvalid after release; streak=0.
- Alternating single requests I,D,I,D (no contention) → every request granted the same cycle; streak stays 0.
